and_gate_checker: RTL and testbench



---
 rtl/and_gate_checker.sv | 117 +++++++++++
 tb/tb_and_gate_checker.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/and_gate_checker.sv
// rtl/and_gate_checker.sv - clocked response checker for an AND gate under test
// Optional coverage mask and coverage-gated pass: define AND_CHECK_COV_EN.
`timescale 1ns/1ps
module and_gate_checker #(
    parameter int LAT     = 1,
    parameter int RUN_LEN = 600,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_a,
    input  logic             in_b,
    input  logic             dut_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err,
    output logic             first_err_vld
`ifdef AND_CHECK_COV_EN
    ,
    output logic [3:0]       cov_mask
`endif
);

    typedef enum logic [1:0] {IDLE, FILL, CHECK, DONE} state_t;

    localparam logic [2:0]       FILL_LAST = (LAT == 0) ? 3'd0 : 3'(LAT - 1);
    localparam logic [CNT_W-1:0] N_LAST    = CNT_W'(RUN_LEN - 1);

    state_t           state_q, state_d;
    logic [2:0]       fill_q;
    logic [CNT_W-1:0] n_q;
    logic [1:0]       ab_d;
    logic             accept;
    logic             mismatch;

    // The input pair is delayed rather than just its AND, so coverage can see it.
    generate
        if (LAT == 0) begin : g_nolat
            assign ab_d = {in_a, in_b};
        end else begin : g_pipe
            logic [1:0] pipe [LAT];
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < LAT; i++) pipe[i] <= 2'b00;
                end else begin
                    pipe[0] <= {in_a, in_b};
                    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign ab_d = pipe[LAT-1];
        end
    endgenerate

    assign accept   = start && (state_q == IDLE || state_q == DONE);
    assign mismatch = (dut_y !== (ab_d[1] & ab_d[0]));

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = (LAT == 0) ? CHECK : FILL;
            FILL:       if (fill_q == FILL_LAST) state_d = CHECK;
            CHECK:      if (n_q == N_LAST) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_q <= 3'd0;
            n_q    <= '0;
        end else if (accept) begin
            fill_q <= 3'd0;
            n_q    <= '0;
        end else if (state_q == FILL) begin
            fill_q <= fill_q + 3'd1;
        end else if (state_q == CHECK) begin
            n_q <= n_q + 1'b1;
        end
    end

    // Results clear on the accepting edge, which is the entry edge of FILL or CHECK.
    always_ff @(posedge clk) begin
        if (!rst_n || accept) begin
            err_cnt       <= '0;
            first_err     <= '0;
            first_err_vld <= 1'b0;
        end else if (state_q == CHECK && mismatch) begin
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            if (!first_err_vld) begin
                first_err     <= n_q;
                first_err_vld <= 1'b1;
            end
        end
    end

    assign busy = (state_q == FILL) || (state_q == CHECK);
    assign done = (state_q == DONE);

`ifdef AND_CHECK_COV_EN
    always_ff @(posedge clk) begin
        if (!rst_n || accept)     cov_mask <= 4'b0000;
        else if (state_q == CHECK) cov_mask[ab_d] <= 1'b1;
    end
    assign pass = done && (err_cnt == '0) && (cov_mask == 4'b1111);
`else
    assign pass = done && (err_cnt == '0);
`endif

endmodule

// File: tb/tb_and_gate_checker.sv
// tb/tb_and_gate_checker.sv - randomized self-checking bench for and_gate_checker
`timescale 1ns/1ps
module tb_and_gate_checker;

    localparam int LAT     = 1;
    localparam int RUN_LEN = 8;
    localparam int CNT_W   = 16;
    localparam int RUN_CYC = LAT + RUN_LEN;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             in_a = 1'b0;
    logic             in_b = 1'b0;
    logic             dut_y;
    logic             busy, done, pass, first_err_vld;
    logic [CNT_W-1:0] err_cnt, first_err;
`ifdef AND_CHECK_COV_EN
    logic [3:0]       cov_mask;
`endif

    logic gate_q  = 1'b0;
    logic ovr_en  = 1'b0;
    logic ovr_val = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;

    logic a_arr [16];
    logic b_arr [16];
    logic y_arr [16];
    int   m_err, m_first, t_bad;
    logic m_vld, m_pass;
    logic [3:0] m_cov;

    always #5 clk = ~clk;

    // Device under test stand-in: a registered AND gate with injectable faults.
    always_ff @(posedge clk) gate_q <= in_a & in_b;
    assign dut_y = ovr_en ? ovr_val : gate_q;

    and_gate_checker #(.LAT(LAT), .RUN_LEN(RUN_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_a(in_a), .in_b(in_b),
        .dut_y(dut_y), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .first_err(first_err), .first_err_vld(first_err_vld)
`ifdef AND_CHECK_COV_EN
        , .cov_mask(cov_mask)
`endif
    );

    function automatic logic [1:0] pat_ab(input int pat, input int i);
        case (pat)
            0:       return 2'(i % 4);
            1:       return 2'($urandom_range(0, 3));
            default: return 2'b11;
        endcase
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; ovr_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Pulse start, play one run, record what the gate saw, then score it from the recording.
    task automatic drive_run(input int pat, input int fault);
        logic [1:0] ab;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t_bad = 0;
        for (int i = 0; i < RUN_CYC; i++) begin
            ab = pat_ab(pat, i);
            in_a = ab[1]; in_b = ab[0];
            a_arr[i] = ab[1]; b_arr[i] = ab[0];
            case (fault)
                1: begin ovr_en = (i == 3 + LAT); ovr_val = ~gate_q; end
                2: begin ovr_en = 1'b1; ovr_val = 1'b1; end
                3: begin ovr_en = ($urandom_range(0, 3) == 0); ovr_val = ~gate_q; end
                default: ovr_en = 1'b0;
            endcase
            #1;
            y_arr[i] = dut_y;
            if (busy !== 1'b1 || done !== 1'b0) t_bad++;
            @(posedge clk); #1;
        end
        ovr_en = 1'b0;
        m_err = 0; m_first = 0; m_vld = 1'b0; m_cov = 4'b0000;
        for (int n = 0; n < RUN_LEN; n++) begin
            m_cov[{a_arr[n], b_arr[n]}] = 1'b1;
            if (y_arr[n + LAT] !== (a_arr[n] & b_arr[n])) begin
                m_err++;
                if (!m_vld) begin m_first = n; m_vld = 1'b1; end
            end
        end
`ifdef AND_CHECK_COV_EN
        m_pass = (m_err == 0) && (m_cov == 4'b1111);
`else
        m_pass = (m_err == 0);
`endif
    endtask

    task automatic test_reset();
        tests_run++;
        if ({busy, done, pass, first_err_vld} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags got %b want 0000", {busy, done, pass, first_err_vld});
        end
        tests_run++;
        if (err_cnt !== '0 || first_err !== '0) begin
            tests_failed++;
            $display("FAIL reset_counts got err=%0d first=%0d want 0 0", err_cnt, first_err);
        end
    endtask

    task automatic test_clean();
        drive_run(0, 0);
        tests_run++;
        if (t_bad != 0 || done !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL clean_timing got bad=%0d done=%b busy=%b want 0 1 0", t_bad, done, busy);
        end
        tests_run++;
        if (pass !== 1'b1 || err_cnt !== '0 || first_err_vld !== 1'b0 || m_err != 0) begin
            tests_failed++;
            $display("FAIL clean_result got pass=%b err=%0d vld=%b want 1 0 0", pass, err_cnt, first_err_vld);
        end
`ifdef AND_CHECK_COV_EN
        tests_run++;
        if (cov_mask !== 4'b1111) begin
            tests_failed++;
            $display("FAIL clean_cov got %b want 1111", cov_mask);
        end
`endif
    endtask

    task automatic test_single_fault();
        drive_run(0, 1);
        tests_run++;
        if (err_cnt !== CNT_W'(1) || first_err !== CNT_W'(3) || first_err_vld !== 1'b1 || pass !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_fault got err=%0d first=%0d vld=%b pass=%b want 1 3 1 0",
                     err_cnt, first_err, first_err_vld, pass);
        end
    endtask

    task automatic test_stuck();
        drive_run(0, 2);
        tests_run++;
        if (err_cnt !== CNT_W'(6) || first_err !== CNT_W'(0) || first_err_vld !== 1'b1 || pass !== 1'b0) begin
            tests_failed++;
            $display("FAIL stuck_one got err=%0d first=%0d vld=%b pass=%b want 6 0 1 0",
                     err_cnt, first_err, first_err_vld, pass);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            drive_run(1, 3);
            tests_run++;
            if (t_bad != 0 || done !== 1'b1 || err_cnt !== CNT_W'(m_err) || first_err_vld !== m_vld ||
                (m_vld && first_err !== CNT_W'(m_first)) || pass !== m_pass) begin
                tests_failed++;
                $display("FAIL random_run%0d got err=%0d first=%0d vld=%b pass=%b bad=%0d want %0d %0d %b %b 0",
                         r, err_cnt, first_err, first_err_vld, pass, t_bad, m_err, m_first, m_vld, m_pass);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] ab;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < LAT + 4; i++) begin
            ab = pat_ab(0, i);
            in_a = ab[1]; in_b = ab[0];
            ovr_en = 1'b1; ovr_val = 1'b1;
            @(posedge clk); #1;
        end
        tests_run++;
        if (busy !== 1'b1 || err_cnt === '0) begin
            tests_failed++;
            $display("FAIL midrun_before got busy=%b err=%0d want 1 nonzero", busy, err_cnt);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; ovr_en = 1'b0;
        tests_run++;
        if ({busy, done, pass, first_err_vld} !== 4'b0000 || err_cnt !== '0 || first_err !== '0) begin
            tests_failed++;
            $display("FAIL midrun_reset got flags=%b err=%0d first=%0d want 0000 0 0",
                     {busy, done, pass, first_err_vld}, err_cnt, first_err);
        end
        drive_run(0, 0);
        tests_run++;
        if (pass !== 1'b1 || done !== 1'b1 || err_cnt !== '0) begin
            tests_failed++;
            $display("FAIL midrun_fresh got pass=%b done=%b err=%0d want 1 1 0", pass, done, err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] ab;
        logic       want_done;
        start = 1'b1;
        @(posedge clk); #1;
        for (int j = 0; j < 3 * (RUN_CYC + 1); j++) begin
            ab = pat_ab(0, j);
            in_a = ab[1]; in_b = ab[0];
            #1;
            want_done = ((j % (RUN_CYC + 1)) == RUN_CYC);
            tests_run++;
            if (done !== want_done || busy !== !want_done || (want_done && pass !== 1'b1)) begin
                tests_failed++;
                $display("FAIL back_to_back cyc%0d got done=%b busy=%b pass=%b want done=%b",
                         j, done, busy, pass, want_done);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

`ifdef AND_CHECK_COV_EN
    task automatic test_cov_11();
        drive_run(2, 0);
        tests_run++;
        if (err_cnt !== '0 || cov_mask !== 4'b1000 || pass !== 1'b0) begin
            tests_failed++;
            $display("FAIL cov_11 got err=%0d cov=%b pass=%b want 0 1000 0", err_cnt, cov_mask, pass);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1);
    end

    initial begin
        do_reset();
        test_reset();
        test_clean();
        test_single_fault();
        test_stuck();
        test_random();
        test_reset_mid();
        test_back_to_back();
        do_reset();
        test_reset();
`ifdef AND_CHECK_COV_EN
        test_cov_11();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
